// File: rtl/progmem_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package progmem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } loader_state_t;

  localparam int PROG_DEPTH = 32;
  localparam int PROG_LEN_W = 6;

endpackage

// File: rtl/progmem_loader.sv
// Byte-stream writer for the program memory: assembles {hi,lo} instructions,
// holds the CPU clock-enable low while loading and checks a trailing XOR sum.
module progmem_loader
  import progmem_loader_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16,
  parameter int BYTE_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [ADDR_W:0]    i_len,
  input  logic [BYTE_W-1:0]  i_byte,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_wr_en,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [INSTR_W-1:0] o_wr_data,
  output logic               o_cpu_ce,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1 << ADDR_W);

  loader_state_t      state, next;
  logic [BYTE_W-1:0]  hi;
  logic [BYTE_W-1:0]  csum;
  logic [ADDR_W-1:0]  addr;
  logic [LEN_W-1:0]   count;
  logic [LEN_W-1:0]   len;
  logic               xfer;
  logic               len_ok;
  logic               in_load;
  logic               next_load;

  assign xfer    = i_valid & o_ready;
  assign len_ok  = (i_len != '0) && (i_len <= DEPTH);
  assign in_load = (state == HI) || (state == LO) || (state == WRITE) || (state == CHECK);

  // Abort outranks any same-cycle transfer, which also drops a pending write.
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (i_start) next = len_ok ? HI : DONE;
      HI:      if (i_abort) next = DONE; else if (xfer) next = LO;
      LO:      if (i_abort) next = DONE; else if (xfer) next = WRITE;
      WRITE:   if (i_abort) next = DONE;
               else next = (count + 1'b1 == len) ? CHECK : HI;
      CHECK:   if (i_abort || xfer) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign next_load = (next == HI) || (next == LO) || (next == WRITE) || (next == CHECK);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      o_ready   <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_cpu_ce  <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_error   <= 1'b0;
      hi        <= '0;
      csum      <= '0;
      addr      <= '0;
      count     <= '0;
      len       <= '0;
    end else begin
      // Status outputs are registered views of the state being entered.
      state    <= next;
      o_ready  <= (next == HI) || (next == LO) || (next == CHECK);
      o_wr_en  <= (next == WRITE);
      o_busy   <= next_load;
      o_cpu_ce <= !next_load;
      o_done   <= (next == DONE);

      case (state)
        IDLE: if (i_start) begin
          if (len_ok) begin
            len     <= i_len;
            addr    <= '0;
            count   <= '0;
            csum    <= '0;
            o_error <= 1'b0;
          end else begin
            o_error <= 1'b1;
          end
        end
        HI: if (!i_abort && xfer) begin
          hi   <= i_byte;
          csum <= csum ^ i_byte;
        end
        LO: if (!i_abort && xfer) begin
          o_wr_data <= {hi, i_byte};
          o_wr_addr <= addr;
          csum      <= csum ^ i_byte;
        end
        WRITE: begin
          addr  <= addr + 1'b1;
          count <= count + 1'b1;
        end
        CHECK: if (!i_abort && xfer) o_error <= (i_byte != csum);
        default: ;
      endcase

      if (in_load && i_abort) o_error <= 1'b1;
    end
  end

endmodule
